// File: rtl/pulpemu_uart_rx_pkg.sv
// Shared types and constants for the pulpemu UART receiver.
// The parity variant is enabled by defining PULPEMU_UART_RX_PARITY_EN.
package pulpemu_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } uart_rx_state_e;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] SAMPLE_A    = 4'd7;
    localparam logic [3:0] SAMPLE_B    = 4'd8;
    localparam logic [3:0] SAMPLE_C    = 4'd9;
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/pulpemu_uart_rx_fifo.sv
// First-word fall-through FIFO for received bytes; pointers carry an extra
// wrap bit so full and empty are distinguishable.
module pulpemu_uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // A simultaneous pop frees the slot being written, so push proceeds even when full.
    assign push_ok_s = push && (!full || pop);
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage array, cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pulpemu_uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 7/8/9 majority vote and receive FIFO.
// Define PULPEMU_UART_RX_PARITY_EN to add a parity bit with parity_odd_i/parity_err_o.
module pulpemu_uart_rx
    import pulpemu_uart_pkg::*;
#(
    parameter int BAUD_DIV   = 27,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       rx_i,
`ifdef PULPEMU_UART_RX_PARITY_EN
    input  logic       parity_odd_i,
    output logic       parity_err_o,
`endif
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int TW = $clog2(BAUD_DIV);

    uart_rx_state_e state_r;
    uart_rx_state_e state_next_s;

    logic          rx_meta_r;
    logic          rx_sync_r;
    logic          rx_prev_r;
    logic [TW-1:0] tick_cnt_r;
    logic [3:0]    sample_cnt_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          samp_a_r;
    logic          samp_b_r;
    logic          frame_err_r;
    logic          overrun_r;

    logic          tick_s;
    logic          decide_s;
    logic          rollover_s;
    logic          maj_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          frame_err_s;
    logic          overrun_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;

`ifdef PULPEMU_UART_RX_PARITY_EN
    logic          parity_odd_r;
    logic          drop_r;
    logic          parity_err_r;
    logic          parity_err_s;
    assign drop_s       = drop_r;
    assign parity_err_o = parity_err_r;
`else
    assign drop_s = 1'b0;
`endif

    assign tick_s      = (tick_cnt_r == TW'(BAUD_DIV - 1));
    assign decide_s    = tick_s && (sample_cnt_r == SAMPLE_C);
    assign rollover_s  = tick_s && (sample_cnt_r == LAST_SAMPLE);
    assign maj_s       = majority3(samp_a_r, samp_b_r, rx_sync_r);
    assign pop_s       = ready_i && !fifo_empty_s;
    assign valid_o     = !fifo_empty_s;
    assign busy_o      = (state_r != IDLE);
    assign frame_err_o = frame_err_r;
    assign overrun_o   = overrun_r;

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-frame event strobes.
    always_comb begin
        state_next_s = state_r;
        push_s       = 1'b0;
        frame_err_s  = 1'b0;
        overrun_s    = 1'b0;
`ifdef PULPEMU_UART_RX_PARITY_EN
        parity_err_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (decide_s && maj_s) begin
                    state_next_s = IDLE;
                end else if (rollover_s) begin
                    state_next_s = DATA;
                end else begin
                    state_next_s = START;
                end
            end
            DATA: begin
                if (rollover_s && (bit_cnt_r == 3'd7)) begin
`ifdef PULPEMU_UART_RX_PARITY_EN
                    state_next_s = PARITY;
`else
                    state_next_s = STOP;
`endif
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
`ifdef PULPEMU_UART_RX_PARITY_EN
                if (decide_s && ((parity8(shift_r) ^ maj_s) != parity_odd_r)) begin
                    parity_err_s = 1'b1;
                end else begin
                    parity_err_s = 1'b0;
                end
`endif
                if (rollover_s) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = PARITY;
                end
            end
            STOP: begin
                // Leave at the decision rather than sample 15 to tolerate skew on back-to-back frames.
                if (decide_s && maj_s) begin
                    state_next_s = IDLE;
                    if (drop_s) begin
                        push_s = 1'b0;
                    end else if (fifo_full_s && !pop_s) begin
                        overrun_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end else if (decide_s) begin
                    frame_err_s  = 1'b1;
                    state_next_s = BRK;
                end else begin
                    state_next_s = STOP;
                end
            end
            BRK: begin
                if (rx_sync_r) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BRK;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Input synchronizer, oversampling counters, shift register and pulse outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            rx_prev_r    <= 1'b1;
            tick_cnt_r   <= '0;
            sample_cnt_r <= 4'd0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'd0;
            samp_a_r     <= 1'b1;
            samp_b_r     <= 1'b1;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            rx_meta_r   <= rx_i;
            rx_sync_r   <= rx_meta_r;
            rx_prev_r   <= rx_sync_r;
            frame_err_r <= frame_err_s;
            overrun_r   <= overrun_s;
            if (state_r == IDLE) begin
                tick_cnt_r   <= '0;
                sample_cnt_r <= 4'd0;
                bit_cnt_r    <= 3'd0;
            end else begin
                tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TW'(1);
                if (tick_s) begin
                    sample_cnt_r <= sample_cnt_r + 4'd1;
                end
                if ((state_r == DATA) && rollover_s) begin
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
            end
            if (tick_s && (sample_cnt_r == SAMPLE_A)) begin
                samp_a_r <= rx_sync_r;
            end
            if (tick_s && (sample_cnt_r == SAMPLE_B)) begin
                samp_b_r <= rx_sync_r;
            end
            if ((state_r == DATA) && decide_s) begin
                shift_r <= {maj_s, shift_r[7:1]};
            end
        end
    end

`ifdef PULPEMU_UART_RX_PARITY_EN
    // Parity mode capture at frame start and per-frame drop flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            parity_odd_r <= 1'b0;
            drop_r       <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= parity_err_s;
            if ((state_r == IDLE) && (state_next_s == START)) begin
                parity_odd_r <= parity_odd_i;
                drop_r       <= 1'b0;
            end else if (parity_err_s) begin
                drop_r <= 1'b1;
            end
        end
    end
`endif

    pulpemu_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .push  (push_s),
        .wdata (shift_r),
        .full  (fifo_full_s),
        .pop   (pop_s),
        .rdata (data_o),
        .empty (fifo_empty_s)
    );

endmodule

// File: tb/tb_pulpemu_uart_rx.sv
// Scoreboard bench for pulpemu_uart_rx at BAUD_DIV=4 (64 clocks per bit).
module tb_pulpemu_uart_rx;

    localparam int BAUD_DIV = 4;
    localparam int BIT_CYC  = 16 * BAUD_DIV;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef PULPEMU_UART_RX_PARITY_EN
    logic       parity_odd = 1'b0;
    logic       parity_err;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fe_cnt    = 0;
    int ov_cnt    = 0;
    int pe_cnt    = 0;
    int pop_cnt   = 0;
    logic [7:0] exp_q[$];

    pulpemu_uart_rx #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .rx_i         (rx),
`ifdef PULPEMU_UART_RX_PARITY_EN
        .parity_odd_i (parity_odd),
        .parity_err_o (parity_err),
`endif
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .frame_err_o  (frame_err),
        .overrun_o    (overrun),
        .busy_o       (busy)
    );

    always #10 clk = ~clk;

    // Monitor: pops the scoreboard on every accepted beat and counts pulses.
    always @(negedge clk) begin
        if (rstn) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
`ifdef PULPEMU_UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            if (valid && ready) begin
                logic [7:0] e;
                pop_cnt++;
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard: got unexpected byte 0x%02h, expected none", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data === e) pass_cnt++;
                    else $display("FAIL scoreboard: got 0x%02h expected 0x%02h", data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic use_par, input logic par);
        rx = 1'b0;
        cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cyc(BIT_CYC);
        end
        if (use_par) begin
            rx = par;
            cyc(BIT_CYC);
        end
        rx = stop_bit;
        cyc(BIT_CYC);
    endtask

    int fe0, ov0, pop0;

    initial begin
        cyc(3);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        cyc(10);

        // Plain frame
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        cyc(BIT_CYC);
        check("a5_drained", exp_q.size(), 32'd0);
        check("a5_frame_err", fe_cnt, 32'd0);
        check("a5_overrun", ov_cnt, 32'd0);

        // Short glitch is rejected
        pop0 = pop_cnt;
        rx = 1'b0;
        cyc(12);
        rx = 1'b1;
        cyc(100);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_no_pop", pop_cnt - pop0, 32'd0);
        check("glitch_no_fe", fe_cnt, 32'd0);

        // Framing error followed by a long break
        pop0 = pop_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        cyc(1000);
        rx = 1'b1;
        cyc(BIT_CYC);
        check("brk_one_fe", fe_cnt, 32'd1);
        check("brk_no_pop", pop_cnt - pop0, 32'd0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        cyc(BIT_CYC);
        check("post_brk_drained", exp_q.size(), 32'd0);

        // Overrun: nine frames into an eight-entry FIFO
        ready = 1'b0;
        pop0 = pop_cnt;
        for (int b = 0; b < 9; b++) begin
            if (b < 8) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1, 1'b0, 1'b0);
        end
        cyc(BIT_CYC);
        check("ovr_one_pulse", ov_cnt, 32'd1);
        check("ovr_valid", {31'd0, valid}, 32'd1);
        check("ovr_head", {24'd0, data}, 32'd0);
        ready = 1'b1;
        cyc(20);
        check("ovr_drained", exp_q.size(), 32'd0);
        check("ovr_pop_count", pop_cnt - pop0, 32'd8);
        check("ovr_valid_low", {31'd0, valid}, 32'd0);

        // Reset during data bit 3 of 0xFF
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx = 1'b0;
        cyc(BIT_CYC);
        rx = 1'b1;
        cyc(3 * BIT_CYC + 30);
        rstn = 1'b0;
        cyc(2);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_data", {24'd0, data}, 32'd0);
        rstn = 1'b1;
        cyc(6 * BIT_CYC);
        pop0 = pop_cnt;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        cyc(BIT_CYC);
        check("midrst_drained", exp_q.size(), 32'd0);
        check("midrst_pop_count", pop_cnt - pop0, 32'd1);
        check("midrst_no_fe", fe_cnt - fe0, 32'd0);
        check("midrst_no_ovr", ov_cnt - ov0, 32'd0);

`ifdef PULPEMU_UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity bit 1 is correct
        parity_odd = 1'b0;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        cyc(BIT_CYC);
        check("par_ok_drained", exp_q.size(), 32'd0);
        check("par_ok_no_err", pe_cnt, 32'd0);
        pop0 = pop_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        cyc(BIT_CYC);
        check("par_bad_err", pe_cnt, 32'd1);
        check("par_bad_no_pop", pop_cnt - pop0, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pulpemu_uart_rx.md
Name: pulpemu_uart_rx

Overview:
- FPGA-side UART receiver for the pulpemu emulation top.
- Samples the chip's UART TX line (the pad routed to the FMC UART TX pin) and recovers 8N1 frames using 16x oversampling with mid-bit majority voting.
- Buffers received bytes in a small FIFO with a valid/ready output, so on-FPGA debug logic can capture console output without a host-side adapter.
- Clocked from the 50 MHz peripheral clock.

Parameters:
- BAUD_DIV, 27, clk_i cycles per oversample tick (50 MHz / (16 × 115200) ≈ 27); legal range ≥2.
- FIFO_DEPTH, 8, receive FIFO entries; power of two, ≥2.

Ports:
- clk_i  input  1  peripheral clock (50 MHz).
- rstn_i  input  1  reset; asynchronous, active-low.
- rx_i  input  1  serial line from the chip's UART TX; asynchronous, idle high.
- data_o  output  8  FIFO head byte; valid only while valid_o=1.
- valid_o  output  1  FIFO not empty.
- ready_i  input  1  consumer accepts data_o; pop on valid_o&ready_i.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled 0.
- overrun_o  output  1  one-cycle pulse: good byte dropped, FIFO full.
- busy_o  output  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
  - Synchronizer flops reset to 1; FSM=IDLE; FIFO empty; counters 0.
- Input synchronization: 2-FF synchronizer on rx_i; all logic below uses the synchronized value rx_s.
- Tick counter:
  - Counts 0..BAUD_DIV-1 and asserts tick when it equals BAUD_DIV-1, then wraps.
  - Forced to 0 in IDLE.
- Sample counter: 4 bits, advances on tick, 0..15 per bit. Samples 7, 8, 9 are recorded; the bit value is their majority, decided on the tick at sample 9.
- FSM states: IDLE, START, DATA, STOP, BRK.
  - IDLE: rx_s 1→0 edge → START, counters cleared.
  - START: at decision, majority=1 → IDLE (glitch reject, no flag); majority=0 → DATA at sample 15 rollover.
  - DATA: 8 bits, LSB first, shifted into the shift register at each decision; after bit 7 rollover → STOP.
  - STOP, decision majority=1:
    - Push the byte into the FIFO in the same cycle; → IDLE immediately. Not waiting for sample 15 allows back-to-back frames with up to 6/16 bit timing skew.
    - If the FIFO is full and no pop occurs this cycle: drop the byte, pulse overrun_o.
  - STOP, decision majority=0: pulse frame_err_o, no push; → BRK.
  - BRK: wait until rx_s=1, then → IDLE. A held-low line (break) produces exactly one frame_err_o.
- Latency: valid_o rises on the cycle after the stop-bit decision cycle when the FIFO was empty.
- FIFO behaviour:
  - First-word fall-through; data_o = head entry.
  - Push and pop in the same cycle while full: both proceed, no overrun.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
- Reset mid-frame: asynchronous clear of everything; partial byte discarded; no pulses emitted.

Optional Feature:
- Macro: PULPEMU_UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, and a parity_odd_i input (1 bit; 0=even, 1=odd), sampled at START entry.
  - On mismatch the byte is dropped and parity_err_o (new output, one-cycle pulse, reset 0) fires at the parity decision; the FSM still proceeds to STOP.
- Undefined: pure 8N1; neither port exists.

Decomposition:
- Package pulpemu_uart_pkg holds:
  - state enum uart_rx_state_e {IDLE, START, DATA, PARITY, STOP, BRK};
  - OVERSAMPLE=16;
  - SAMPLE_A/B/C=7/8/9;
  - LAST_SAMPLE=15.
- One sub-module, pulpemu_uart_rx_fifo: parameterized by DEPTH and WIDTH, FWFT, exposing push/full/pop/empty.

Test Plan (BAUD_DIV=4, one bit = 64 cycles):
- Send 0xA5 8N1, ready_i=1 → one valid_o beat with data_o=0xA5; frame_err_o and overrun_o stay 0.
- Drive rx_i low for 12 cycles then high → FSM returns to IDLE, no valid_o, no error pulses.
- Send 0x3C with stop bit=0, then hold rx_i low for 1000 cycles, then release → exactly one frame_err_o pulse, no push; the next 0x11 frame is received correctly.
- ready_i=0, send 0x00..0x08 back-to-back (FIFO_DEPTH=8) → exactly one overrun_o pulse during byte 0x08; raising ready_i pops 0x00..0x07 in order.
- Assert rstn_i low during data bit 3 of 0xFF, release, then send 0x42 → only 0x42 appears; busy_o=0 during reset.
- With PULPEMU_UART_RX_PARITY_EN, parity_odd_i=0: 0x07 sent with parity 1 → accepted; same byte with parity 0 → parity_err_o pulse, no valid_o.
